wired_mdu: RTL and testbench

Multiply/divide execution unit at the responder end of the MDU issue-queue request/response interface.
- Accepts one iq_mdu_req_t per handshake.
- Computes a 32-bit multiply or divide result.
- Returns iq_mdu_resp_t carrying the unchanged wid; the issue queue pushes it into its CDB FIFO.
- Single op in flight; flushed together with the backend.

---
 rtl/wired_mdu_pkg.sv | 38 +++
 rtl/wired_mdu_div.sv | 66 ++++++
 rtl/wired_mdu.sv | 156 +++++++++++++++
 tb/tb_wired_mdu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wired_mdu_pkg.sv
// Shared MDU types: issue-queue request/response records, op codes and FSM states.
// Operand magnitude helper used by the divider front end.
package wired0_defines;

    localparam logic [1:0] MDU_MUL  = 2'b00;
    localparam logic [1:0] MDU_MULH = 2'b01;
    localparam logic [1:0] MDU_DIV  = 2'b10;
    localparam logic [1:0] MDU_MOD  = 2'b11;

    localparam int ROB_RID_W = 6;
    typedef logic [ROB_RID_W-1:0] rob_rid_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] r0;
        logic [31:0] r1;
        rob_rid_t    wid;
    } iq_mdu_req_t;

    typedef struct packed {
        rob_rid_t    wid;
        logic [31:0] result;
    } iq_mdu_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/wired_mdu_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, 32 cycles.
// Signs and special cases are resolved by the caller.
module wired_mdu_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill_i,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic        busy;
    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;

    logic [32:0] shifted;
    logic [33:0] diff;

    // Partial remainder is 33 bits wide so the shifted-in bit never overflows.
    assign shifted = {rem[31:0], quo[31]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs};

    always_ff @(posedge clk) begin
        if (!rst_n || kill_i) begin
            busy <= 1'b0;
            cnt  <= 5'd0;
        end else if (start_i) begin
            busy <= 1'b1;
            cnt  <= 5'd0;
        end else if (busy) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                busy <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers carry no reset; busy/cnt alone decide whether they matter.
    always_ff @(posedge clk) begin
        if (start_i) begin
            rem <= 33'd0;
            quo <= dividend_i;
            dvs <= divisor_i;
        end else if (busy) begin
            if (!diff[33]) begin
                rem <= diff[32:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= shifted;
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign busy_o      = busy;
    assign done_o      = busy && (cnt == 5'd31);
    assign quotient_o  = quo;
    assign remainder_o = rem[31:0];

endmodule

// File: rtl/wired_mdu.sv
// Multiply/divide unit behind the issue queue: one op in flight, pipelined
// multiplier, iterative divider with a single-cycle path for special divides.
module wired_mdu
    import wired0_defines::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  iq_mdu_req_t  req_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output iq_mdu_resp_t resp_o
);

    localparam logic [1:0] MUL_LAST = (MUL_LATENCY > 1) ? 2'(MUL_LATENCY - 2) : 2'd0;

    mdu_state_t state, state_nxt;

    logic        accept;
    logic        is_special;
    logic [31:0] special_res;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] fix_res;

    rob_rid_t    wid_q;
    logic [1:0]  op_q;
    logic        q_neg;
    logic        r_neg;
    logic [1:0]  mul_cnt;
    logic [31:0] res_q;

    logic signed [63:0] mul_pipe [MUL_LATENCY];

    assign accept     = req_valid_i && (state == ST_IDLE);
    assign is_special = req_i.op[1] &&
                        ((req_i.r1 == 32'd0) ||
                         ((req_i.r0 == 32'h8000_0000) && (req_i.r1 == 32'hFFFF_FFFF)));
    assign div_start  = accept && req_i.op[1] && !is_special;

    always_comb begin
        if (req_i.r1 == 32'd0) begin
            special_res = (req_i.op == MDU_MOD) ? req_i.r0 : 32'hFFFF_FFFF;
        end else begin
            special_res = (req_i.op == MDU_MOD) ? 32'd0 : 32'h8000_0000;
        end
    end

    assign fix_res = (op_q == MDU_DIV) ? (q_neg ? (32'd0 - div_quo) : div_quo)
                                       : (r_neg ? (32'd0 - div_rem) : div_rem);

    wired_mdu_div u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .kill_i      (flush_i),
        .start_i     (div_start),
        .dividend_i  (mag32(req_i.r0)),
        .divisor_i   (mag32(req_i.r1)),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Multiply written as a product followed by plain register stages so
    // synthesis can retime the partial products; frozen while the result waits.
    always_ff @(posedge clk) begin
        if (state != ST_DONE) begin
            mul_pipe[0] <= $signed(req_i.r0) * $signed(req_i.r1);
            for (int i = 1; i < MUL_LATENCY; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
    end

    // Flush shares reset priority, so an op in flight or a waiting result is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wid_q   <= req_i.wid;
            op_q    <= req_i.op;
            q_neg   <= req_i.r0[31] ^ req_i.r1[31];
            r_neg   <= req_i.r0[31];
            mul_cnt <= 2'd0;
            if (is_special) begin
                res_q <= special_res;
            end
        end else begin
            if (state == ST_MUL) begin
                mul_cnt <= mul_cnt + 2'd1;
            end
            if (state == ST_FIX) begin
                res_q <= fix_res;
            end
        end
    end

    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_i.op[1]) begin
                        state_nxt = (MUL_LATENCY == 1) ? ST_DONE : ST_MUL;
                    end else begin
                        state_nxt = is_special ? ST_DONE : ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (mul_cnt == MUL_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done || !div_busy) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: begin
                if (resp_ready_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state == ST_IDLE);
        resp_valid_o = (state == ST_DONE);
        resp_o.wid   = wid_q;
        unique case (op_q)
            MDU_MUL:  resp_o.result = mul_pipe[MUL_LATENCY-1][31:0];
            MDU_MULH: resp_o.result = mul_pipe[MUL_LATENCY-1][63:32];
            default:  resp_o.result = res_q;
        endcase
    end

endmodule

// File: tb/tb_wired_mdu.sv
// Directed bench for wired_mdu: vector table for results and latencies, plus
// hand-written backpressure and flush sequences.
module tb_wired_mdu;
    import wired0_defines::*;

    logic         clk;
    logic         rst_n;
    logic         flush_i;
    logic         req_valid_i;
    logic         req_ready_o;
    iq_mdu_req_t  req_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    iq_mdu_resp_t resp_o;

    int n_tests = 0;
    int n_fail  = 0;

    wired_mdu #(.MUL_LATENCY(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_i        (req_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_o       (resp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] r0;
        logic [31:0] r1;
        rob_rid_t    wid;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input rob_rid_t w);
        req_i.op    = op;
        req_i.r0    = a;
        req_i.r1    = b;
        req_i.wid   = w;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    // Latency counts the edge after acceptance at which resp_valid_o is first sampled high.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_resp();
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.op, v.r0, v.r1, v.wid);
        check({v.name, ".ready_busy"}, 32'(req_ready_o), 32'd0);
        wait_resp(lat);
        check({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, ".result"}, resp_o.result, v.exp_res);
        check({v.name, ".wid"}, 32'(resp_o.wid), 32'(v.wid));
        take_resp();
        check({v.name, ".ready_after"}, 32'(req_ready_o), 32'd1);
        check({v.name, ".valid_after"}, 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{"mul_7_m3",      MDU_MUL,  32'd7,          32'hFFFF_FFFD, 6'd5,  32'hFFFF_FFEB, 2};
        vecs[1]  = '{"mulh_min_min",  MDU_MULH, 32'h8000_0000,  32'h8000_0000, 6'd1,  32'h4000_0000, 2};
        vecs[2]  = '{"mulh_m1_2",     MDU_MULH, 32'hFFFF_FFFF,  32'd2,         6'd2,  32'hFFFF_FFFF, 2};
        vecs[3]  = '{"mul_2p16_sq",   MDU_MUL,  32'h0001_0000,  32'h0001_0000, 6'd3,  32'd0,         2};
        vecs[4]  = '{"mulh_2p16_sq",  MDU_MULH, 32'h0001_0000,  32'h0001_0000, 6'd4,  32'd1,         2};
        vecs[5]  = '{"div_m7_2",      MDU_DIV,  32'hFFFF_FFF9,  32'd2,         6'd6,  32'hFFFF_FFFD, 34};
        vecs[6]  = '{"mod_m7_2",      MDU_MOD,  32'hFFFF_FFF9,  32'd2,         6'd7,  32'hFFFF_FFFF, 34};
        vecs[7]  = '{"div_100_7",     MDU_DIV,  32'd100,        32'd7,         6'd8,  32'd14,        34};
        vecs[8]  = '{"mod_100_7",     MDU_MOD,  32'd100,        32'd7,         6'd9,  32'd2,         34};
        vecs[9]  = '{"div_7_m2",      MDU_DIV,  32'd7,          32'hFFFF_FFFE, 6'd10, 32'hFFFF_FFFD, 34};
        vecs[10] = '{"mod_7_m2",      MDU_MOD,  32'd7,          32'hFFFF_FFFE, 6'd11, 32'd1,         34};
        vecs[11] = '{"div_min_2",     MDU_DIV,  32'h8000_0000,  32'd2,         6'd12, 32'hC000_0000, 34};
        vecs[12] = '{"mod_min_3",     MDU_MOD,  32'h8000_0000,  32'd3,         6'd13, 32'hFFFF_FFFE, 34};
        vecs[13] = '{"div_5_0",       MDU_DIV,  32'd5,          32'd0,         6'd14, 32'hFFFF_FFFF, 1};
        vecs[14] = '{"mod_5_0",       MDU_MOD,  32'd5,          32'd0,         6'd15, 32'd5,         1};
        vecs[15] = '{"div_ovf",       MDU_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 6'd16, 32'h8000_0000, 1};
        vecs[16] = '{"mod_ovf",       MDU_MOD,  32'h8000_0000,  32'hFFFF_FFFF, 6'd63, 32'd0,         1};

        rst_n        = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b0;
        req_i        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset.ready", 32'(req_ready_o), 32'd1);
        check("reset.valid", 32'(resp_valid_o), 32'd0);

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held for 5 cycles, then back-to-back MUL.
        issue(MDU_MUL, 32'd6, 32'd7, 6'd3);
        wait_resp(lat);
        check("bp.latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp.valid_held", 32'(resp_valid_o), 32'd1);
            check("bp.result_held", resp_o.result, 32'd42);
            check("bp.wid_held", 32'(resp_o.wid), 32'd3);
            check("bp.ready_low", 32'(req_ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        take_resp();
        check("bp.ready_after", 32'(req_ready_o), 32'd1);
        issue(MDU_MUL, 32'd9, 32'd9, 6'd4);
        wait_resp(lat);
        check("b2b.latency", 32'(lat), 32'd2);
        check("b2b.result", resp_o.result, 32'd81);
        take_resp();

        // Flush ten cycles into a divide.
        issue(MDU_DIV, 32'd100, 32'd7, 6'd20);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_div.ready", 32'(req_ready_o), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid_o) seen++;
            @(posedge clk);
            #1;
        end
        check("flush_div.no_resp", 32'(seen), 32'd0);
        issue(MDU_MUL, 32'd3, 32'd4, 6'd21);
        wait_resp(lat);
        check("post_flush.latency", 32'(lat), 32'd2);
        check("post_flush.result", resp_o.result, 32'd12);
        check("post_flush.wid", 32'(resp_o.wid), 32'd21);
        take_resp();

        // Flush coinciding with a request: request dropped.
        flush_i = 1'b1;
        issue(MDU_DIV, 32'd5, 32'd0, 6'd22);
        flush_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid_o) seen++;
            @(posedge clk);
            #1;
        end
        check("flush_req.no_resp", 32'(seen), 32'd0);
        check("flush_req.ready", 32'(req_ready_o), 32'd1);

        // Flush wins over a handshake in DONE.
        issue(MDU_MUL, 32'd2, 32'd5, 6'd23);
        wait_resp(lat);
        check("flush_done.valid", 32'(resp_valid_o), 32'd1);
        flush_i      = 1'b1;
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        check("flush_done.valid_after", 32'(resp_valid_o), 32'd0);
        check("flush_done.ready_after", 32'(req_ready_o), 32'd1);
        issue(MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd24);
        wait_resp(lat);
        check("final.result", resp_o.result, 32'd0);
        take_resp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
